text_write_queue: RTL and testbench

TEXT_WRITE_QUEUE -- requirements
Module: text_write_queue

---
 rtl/text_write_queue_if.sv | 23 ++
 rtl/text_write_queue.sv | 144 ++++++++++++++
 tb/tb_text_write_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_write_queue_if.sv
// Video-RAM write port between text_write_queue (master) and the RAM arbiter (slave).
interface text_write_queue_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              ram_req;
  logic              ram_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [23:0]       ram_data;

  modport master (
    output ram_req,
    output ram_addr,
    output ram_data,
    input  ram_ack
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    input  ram_data,
    output ram_ack
  );
endinterface

// File: rtl/text_write_queue.sv
// Queues character writes from the I2C register stage and issues them to the video-RAM arbiter.
// Optional macro TEXT_WRITE_CLIP_EN discards pushes whose column/row lies outside the screen.
module text_write_queue #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 25,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                character_change,
  input  logic [7:0]          character,
  input  logic [7:0]          xtext,
  input  logic [7:0]          ytext,
  input  logic [7:0]          attribute1,
  input  logic [7:0]          attribute2,
  text_write_queue_if.master  ram,
  output logic                overflow,
  input  logic                overflow_clr,
  output logic                busy
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned ENTRY_W = ADDR_W + 24;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e                state_q, state_d;
  logic                  chg_q;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_inc, rd_inc;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  req_q, req_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [23:0]           data_q, data_d;

  logic                  push_raw, push, pop, push_ok;
  logic [31:0]           addr_full;
  logic [ENTRY_W-1:0]    entry_in, head;

  // Address arithmetic is done at 32 bits and only then truncated to the RAM width.
  assign addr_full = {24'd0, ytext} * COLS + {24'd0, xtext};
  assign entry_in  = {addr_full[ADDR_W-1:0], attribute2, attribute1, character};
  assign head      = mem[rd_ptr_q];

  assign push_raw = character_change & ~chg_q;
`ifdef TEXT_WRITE_CLIP_EN
  logic in_range;
  assign in_range = ({24'd0, xtext} < COLS) && ({24'd0, ytext} < ROWS);
  assign push     = push_raw & in_range;
`else
  assign push     = push_raw;
`endif

  assign pop     = (state_q == StIdle) && !empty_q;
  assign push_ok = push && (!full_q || pop);
  assign wr_inc  = wr_ptr_q + DEPTH_LOG2'(1);
  assign rd_inc  = rd_ptr_q + DEPTH_LOG2'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_inc;
    if (pop)     rd_ptr_d = rd_inc;
    // Simultaneous push and pop leaves the occupancy, and hence both flags, unchanged.
    if (push_ok && !pop) begin
      empty_d = 1'b0;
      full_d  = (wr_inc == rd_ptr_q);
    end else if (pop && !push_ok) begin
      full_d  = 1'b0;
      empty_d = (rd_inc == wr_ptr_q);
    end
    if (overflow_clr)        ovf_d = 1'b0;
    if (push && !push_ok)    ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (!empty_q) begin
          addr_d  = head[ENTRY_W-1:24];
          data_d  = head[23:0];
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (ram.ram_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      chg_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      chg_q    <= character_change;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= entry_in;
  end

  assign ram.ram_req  = req_q;
  assign ram.ram_addr = addr_q;
  assign ram.ram_data = data_q;
  assign overflow     = ovf_q;
  assign busy         = !empty_q || req_q;

endmodule

// File: tb/tb_text_write_queue.sv
// Randomised scoreboard bench for text_write_queue with directed scenarios up front.
module tb_text_write_queue;
  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 25;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       character_change = 1'b0;
  logic [7:0] character = '0, xtext = '0, ytext = '0, attribute1 = '0, attribute2 = '0;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  text_write_queue_if #(.ADDR_W(ADDR_W)) ram ();

  text_write_queue #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .ADDR_W    (ADDR_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .character_change(character_change),
    .character       (character),
    .xtext           (xtext),
    .ytext           (ytext),
    .attribute1      (attribute1),
    .attribute2      (attribute2),
    .ram             (ram),
    .overflow        (overflow),
    .overflow_clr    (overflow_clr),
    .busy            (busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  total = 0, bad = 0, writes = 0, outstanding = 0, ack_mode = 0;
  bit  prev_chg = 1'b1, exp_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted push becomes an expected write; the queue plus the
  // in-flight request hold at most DEPTH+1 entries, anything beyond that is lost.
  bit          m_push, m_in_range;
  int unsigned m_full_addr;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      outstanding = 0;
      prev_chg    = 1'b1;
      exp_ovf     = 1'b0;
    end else begin
      m_push     = character_change && !prev_chg;
      prev_chg   = character_change;
      m_in_range = (int'(xtext) < COLS) && (int'(ytext) < ROWS);
`ifdef TEXT_WRITE_CLIP_EN
      if (!m_in_range) m_push = 1'b0;
`endif
      if (overflow_clr) exp_ovf = 1'b0;
      if (m_push && outstanding == DEPTH + 1) begin
        exp_ovf = 1'b1;
      end else if (m_push) begin
        m_full_addr = int'(ytext) * COLS + int'(xtext);
        exp_q.push_back(wr_t'{addr: ADDR_W'(m_full_addr % (32'd1 << ADDR_W)),
                              data: {attribute2, attribute1, character}});
        outstanding++;
      end
      if (ram.ram_req && ram.ram_ack) outstanding--;
    end
  end

  // Monitor: compares each completed write against the scoreboard and checks the handshake.
  logic              prev_req = 1'b0, prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [23:0]       prev_data = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_req && !prev_ack) begin
        check("req_hold", 32'(ram.ram_req), 32'(1));
        check("addr_hold", 32'(ram.ram_addr), 32'(prev_addr));
        check("data_hold", 32'(ram.ram_data), 32'(prev_data));
      end
      if (prev_req && prev_ack) check("idle_gap", 32'(ram.ram_req), 32'(0));
      if (ram.ram_req && ram.ram_ack) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   ram.ram_addr, ram.ram_data);
        end else begin
          exp_e = exp_q.pop_front();
          if (ram.ram_addr !== exp_e.addr || ram.ram_data !== exp_e.data) begin
            bad++;
            $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                     ram.ram_addr, ram.ram_data, exp_e.addr, exp_e.data);
          end
        end
        writes++;
      end
    end
    prev_req  = reset_n && ram.ram_req;
    prev_ack  = ram.ram_ack;
    prev_addr = ram.ram_addr;
    prev_data = ram.ram_data;
  end

  // Arbiter: 0 = never grant, 1 = grant one cycle after request, else random (also in idle).
  initial ram.ram_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       ram.ram_ack = 1'b0;
      1:       ram.ram_ack = ram.ram_req;
      default: ram.ram_ack = ($urandom_range(0, 2) == 0);
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_char(input int x, input int y, input int ch, input int a1, input int a2);
    xtext            = 8'(x);
    ytext            = 8'(y);
    character        = 8'(ch);
    attribute1       = 8'(a1);
    attribute2       = 8'(a2);
    character_change = 1'b1;
    tick(1);
    character_change = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s: drain timeout with %0d writes still expected", name, exp_q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int w0;
  initial begin
    #12;
    check("rst_req", 32'(ram.ram_req), 32'(0));
    check("rst_addr", 32'(ram.ram_addr), 32'(0));
    check("rst_data", 32'(ram.ram_data), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // Flag already high at reset release must not push.
    character_change = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(4);
    check("rel_high_req", 32'(ram.ram_req), 32'(0));
    check("rel_high_busy", 32'(busy), 32'(0));
    character_change = 1'b0;
    tick(2);

    // Single write with latency and busy release.
    ack_mode = 1;
    w0 = writes;
    push_char(3, 2, 'h41, 'h07, 'h00);
    check("latency_req", 32'(ram.ram_req), 32'(1));
    check("single_addr", 32'(ram.ram_addr), 32'd163);
    check("single_data", 32'(ram.ram_data), 32'h000741);
    tick(1);
    check("busy_after_ack", 32'(busy), 32'(0));
    check("single_count", 32'(writes - w0), 32'(1));

    // Arbiter stall.
    ack_mode = 0;
    w0 = writes;
    for (int i = 0; i < 4; i++) push_char(10 + i, 5, 'h61 + i, i, 'h80);
    tick(50);
    check("stall_none", 32'(writes - w0), 32'(0));
    ack_mode = 1;
    drain("stall_drain");
    check("stall_count", 32'(writes - w0), 32'(4));
    check("stall_ovf", 32'(overflow), 32'(0));

    // Overflow: sixth push lost, then clear.
    ack_mode = 0;
    w0 = writes;
    for (int i = 0; i < 6; i++) push_char(i, 7, 'h30 + i, 'h1f, i);
    check("ovf_set", 32'(overflow), 32'(1));
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'(0));
    ack_mode = 1;
    drain("ovf_drain");
    check("ovf_count", 32'(writes - w0), 32'(5));

    // Level hold.
    w0 = writes;
    xtext = 8'd40; ytext = 8'd12; character = 8'h5a;
    character_change = 1'b1;
    tick(20);
    character_change = 1'b0;
    drain("hold_drain");
    check("hold_count", 32'(writes - w0), 32'(1));

    // Reset during an outstanding request with two entries queued.
    ack_mode = 0;
    for (int i = 0; i < 3; i++) push_char(i, 1, 'h70 + i, 0, 0);
    check("mid_req", 32'(ram.ram_req), 32'(1));
    w0 = writes;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(ram.ram_req), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    tick(1);
    reset_n = 1'b1;
    ack_mode = 1;
    tick(20);
    check("mid_no_write", 32'(writes - w0), 32'(0));
    check("mid_idle", 32'(busy), 32'(0));

    // Column past the last one.
    w0 = writes;
    push_char(80, 0, 'h21, 0, 0);
`ifdef TEXT_WRITE_CLIP_EN
    check("clip_req", 32'(ram.ram_req), 32'(0));
    drain("clip_drain");
    check("clip_count", 32'(writes - w0), 32'(0));
`else
    check("noclip_addr", 32'(ram.ram_addr), 32'd80);
    drain("clip_drain");
    check("noclip_count", 32'(writes - w0), 32'(1));
`endif

    // Randomised traffic with random grants, including full-range coordinates.
    ack_mode = 2;
    for (int i = 0; i < 300; i++) begin
      overflow_clr = ($urandom_range(0, 19) == 0);
      push_char($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
      overflow_clr = 1'b0;
      tick($urandom_range(0, 3));
      check("rand_ovf", 32'(overflow), 32'(exp_ovf));
    end
    ack_mode = 1;
    drain("rand_drain");
    check("final_busy", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
